// File: rtl/project_types.sv
// Shared types and constants for the memory-access pipeline stage.
package project_types;

  typedef logic reset_status_t;
  localparam reset_status_t RST_ENABLE = 1'b0;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } reg_t;

  typedef struct packed {
    logic        we;
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LBU,
    MEM_LH,
    MEM_LHU,
    MEM_LW,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } mem_state_t;

  // Bus cycles without an ack before the access is abandoned.
  localparam logic [7:0] MEM_TIMEOUT = 8'd255;

  function automatic logic is_load_op(input mem_op_t op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, alignment checks, and load extraction.
module mem_align
  import project_types::*;
(
  input  mem_op_t     req_op_i,
  input  logic [1:0]  req_addr_lo_i,
  input  logic [31:0] sdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        is_load_o,
  output logic        is_store_o,
  output logic        misaligned_o,
  input  mem_op_t     ld_op_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request side: lane enables, replicated store data and alignment check.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = sdata_i;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    misaligned_o = 1'b0;
    case (req_op_i)
      MEM_LB, MEM_LBU: begin
        is_load_o = 1'b1;
        be_o      = 4'b1111;
      end
      MEM_LH, MEM_LHU: begin
        is_load_o    = 1'b1;
        be_o         = 4'b1111;
        misaligned_o = req_addr_lo_i[0];
      end
      MEM_LW: begin
        is_load_o    = 1'b1;
        be_o         = 4'b1111;
        misaligned_o = |req_addr_lo_i;
      end
      MEM_SB: begin
        is_store_o = 1'b1;
        be_o       = 4'b0001 << req_addr_lo_i;
        wdata_o    = {4{sdata_i[7:0]}};
      end
      MEM_SH: begin
        is_store_o   = 1'b1;
        be_o         = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{sdata_i[15:0]}};
        misaligned_o = req_addr_lo_i[0];
      end
      MEM_SW: begin
        is_store_o   = 1'b1;
        be_o         = 4'b1111;
        misaligned_o = |req_addr_lo_i;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane of the returned word and extend it.
  always_comb begin
    ld_byte   = ld_word_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half   = ld_addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_data_o = ld_word_i;
    case (ld_op_i)
      MEM_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data_o = {24'd0, ld_byte};
      MEM_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues one data-bus access per load/store, stalls the pipe
// while it is outstanding, and hands the result to the MEM/WB latch.
module mem_access
  import project_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  reg_t        mem_wreg_i,
  input  hilo_t       mem_hilo_i,
  input  mem_op_t     mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        dram_req_o,
  output logic        dram_we_o,
  output logic [31:0] dram_addr_o,
  output logic [3:0]  dram_be_o,
  output logic [31:0] dram_wdata_o,
  input  logic        dram_ack_i,
  input  logic [31:0] dram_rdata_i,
  output logic        stall_req_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        exc_bus_o,
  output reg_t        wb_wreg_o,
  output hilo_t       wb_hilo_o
);

  mem_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] load_q, load_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  mem_op_t     op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        bus_err_q, bus_err_d;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_is_load;
  logic        req_is_store;
  logic        req_misaligned;
  logic [31:0] ld_data;
  logic        access_ok;

  mem_align u_align (
    .req_op_i      (mem_op_i),
    .req_addr_lo_i (mem_addr_i[1:0]),
    .sdata_i       (mem_sdata_i),
    .be_o          (req_be),
    .wdata_o       (req_wdata),
    .is_load_o     (req_is_load),
    .is_store_o    (req_is_store),
    .misaligned_o  (req_misaligned),
    .ld_op_i       (op_q),
    .ld_addr_lo_i  (addr_lo_q),
    .ld_word_i     (load_q),
    .ld_data_o     (ld_data)
  );

  assign access_ok = (req_is_load || req_is_store) && !req_misaligned;
  assign cnt_inc   = cnt_q + 8'd1;

  // State and bus registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      load_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      op_q      <= MEM_NONE;
      addr_lo_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      load_q    <= load_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      addr_lo_q <= addr_lo_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic: launch, wait for ack or timeout, then one DONE cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_d    = load_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    op_d      = op_q;
    addr_lo_d = addr_lo_q;
    bus_err_d = bus_err_q;
    case (state_q)
      ST_IDLE: begin
        bus_err_d = 1'b0;
        if (access_ok) begin
          state_d   = ST_REQ;
          req_d     = 1'b1;
          we_d      = req_is_store;
          addr_d    = {mem_addr_i[31:2], 2'b00};
          be_d      = req_be;
          wdata_d   = req_wdata;
          op_d      = mem_op_i;
          addr_lo_d = mem_addr_i[1:0];
          cnt_d     = '0;
        end
      end
      ST_REQ: begin
        if (dram_ack_i) begin
          // An ack always beats a timeout landing in the same cycle.
          load_d  = dram_rdata_i;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == MEM_TIMEOUT) begin
            req_d     = 1'b0;
            bus_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dram_req_o   = req_q;
  assign dram_we_o    = we_q;
  assign dram_addr_o  = addr_q;
  assign dram_be_o    = be_q;
  assign dram_wdata_o = wdata_q;

  // Pipeline-facing outputs: stall, exceptions and the write-back bundle.
  always_comb begin
    stall_req_o = 1'b0;
    exc_adel_o  = 1'b0;
    exc_ades_o  = 1'b0;
    exc_bus_o   = 1'b0;
    wb_wreg_o   = mem_wreg_i;
    wb_hilo_o   = mem_hilo_i;
    if (rst == RST_ENABLE) begin
      wb_wreg_o = '0;
      wb_hilo_o = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_misaligned) begin
            exc_adel_o   = req_is_load;
            exc_ades_o   = req_is_store;
            wb_wreg_o.we = 1'b0;
          end else if (access_ok) begin
            // Nothing valid to write back until the access completes.
            stall_req_o  = 1'b1;
            wb_wreg_o.we = 1'b0;
          end
        end
        ST_REQ: begin
          stall_req_o  = 1'b1;
          wb_wreg_o.we = 1'b0;
        end
        ST_DONE: begin
          if (bus_err_q) begin
            exc_bus_o    = 1'b1;
            wb_wreg_o.we = 1'b0;
          end else if (is_load_op(op_q)) begin
            wb_wreg_o.wdata = ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1 (reset_status_t)  reset is synchronous and active-low; RST_ENABLE = 1'b0.
REQ-003 mem_wreg_i  input  reg_t  EX/MEM register-write bundle {we, waddr[4:0], wdata[31:0]}.
REQ-004 mem_hilo_i  input  hilo_t  EX/MEM HI/LO write bundle {we, hi[31:0], lo[31:0]}.
REQ-005 mem_op_i  input  mem_op_t  access type: MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-006 mem_addr_i  input  32  byte address of the access.
REQ-007 mem_sdata_i  input  32  store data; low byte or halfword is used for SB/SH.
REQ-008 dram_req_o  output  1  bus request, registered.
REQ-009 dram_we_o  output  1  write strobe, valid while dram_req_o is high.
REQ-010 dram_addr_o  output  32  word-aligned address {addr[31:2], 2'b00}.
REQ-011 dram_be_o  output  4  byte enables.
REQ-012 dram_wdata_o  output  32  write data, lane-replicated.
REQ-013 dram_ack_i  input  1  one-cycle completion from memory.
REQ-014 dram_rdata_i  input  32  read word, valid when dram_ack_i is high.
REQ-015 stall_req_o  output  1  holds IF through EX/MEM while an access is in flight.
REQ-016 exc_adel_o / exc_ades_o  output  1 each  misaligned load / misaligned store.
REQ-017 exc_bus_o  output  1  one-cycle pulse on bus timeout.
REQ-018 wb_wreg_o  output  reg_t  result to the MEM/WB latch.
REQ-019 wb_hilo_o  output  hilo_t  HI/LO bundle to the MEM/WB latch.

Function
REQ-020 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-021 IDLE, valid aligned access: stall_req_o = 1 combinationally; latch address, be, wdata and we; next state is REQ with dram_req_o = 1.
REQ-022 IDLE, mem_op_i = MEM_NONE: no request; stall_req_o = 0; wb_wreg_o = mem_wreg_i.
REQ-023 REQ: dram_req_o and all dram_* outputs held stable until dram_ack_i is sampled high; stall_req_o = 1.
REQ-024 REQ, on ack: capture dram_rdata_i into the load register; next state DONE; dram_req_o = 0.
REQ-025 DONE: stall_req_o = 0; a load drives wb_wreg_o = {mem_wreg_i.we, mem_wreg_i.waddr, load_result}; next state IDLE unconditionally.
REQ-026 Minimum latency, arrival to DONE: 2 cycles (ack in first REQ cycle); stall is asserted for exactly 2 cycles in that case.
REQ-027 Byte lanes are little-endian; k = addr[1:0].
  - SB: be = 1<<k, wdata = {4{sdata[7:0]}}.
  - SH: be = 4'b0011 or 4'b1100, wdata = {2{sdata[15:0]}}.
  - SW: be = 4'b1111.
  - Loads: be = 4'b1111, dram_we_o = 0.
REQ-028 Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
REQ-029 Misalignment: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - Raise exc_adel_o (loads) or exc_ades_o (stores) combinationally in IDLE.
  - Issue no request and assert no stall.
  - Force wb_wreg_o.we = 0.
REQ-030 Stores: wb_wreg_o = mem_wreg_i unchanged.
REQ-031 wb_hilo_o = mem_hilo_i in every state.
REQ-032 Timeout: 8-bit counter cleared on REQ entry and incremented each REQ cycle without ack.
  - At MEM_TIMEOUT (255): drop dram_req_o, pulse exc_bus_o, force wb_wreg_o.we = 0, go to DONE.
REQ-033 An ack arriving outside REQ SHALL be ignored.
REQ-034 Ack in the same cycle the counter reaches MEM_TIMEOUT: the ack wins, and exc_bus_o stays 0.

Reset
REQ-035 rst == RST_ENABLE at a posedge: state = IDLE, counter = 0, load register = 0, and all registered dram_* outputs = 0.
REQ-036 While rst == RST_ENABLE: stall_req_o, exc_* = 0, and wb_wreg_o, wb_hilo_o = '{default:0}.
REQ-037 Reset during REQ aborts the access; dram_req_o is low in the cycle after the reset edge.

Structure
REQ-038 project_types SHALL hold: mem_op_t, the state enum, MEM_TIMEOUT, and the existing reg_t, hilo_t, reset_status_t, RST_ENABLE.
REQ-039 Lane steering and extension SHALL live in one combinational sub-module, mem_align.

Verification
REQ-040 LW at 0x100, ack on the first REQ cycle, rdata 0xDEADBEEF -> stall high for 2 cycles; DONE shows wdata = 0xDEADBEEF.
REQ-041 LB at 0x103, rdata 0x80123456 -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-042 SH at 0x202, sdata 0x0000ABCD -> be = 4'b1100, wdata = 0xABCDABCD, dram_addr_o = 0x200.
REQ-043 LW at 0x101 -> exc_adel_o = 1, no dram_req_o, stall = 0, wb we = 0.
REQ-044 No ack for 255 REQ cycles -> exc_bus_o pulses once, FSM passes through DONE to IDLE, stall releases.
REQ-045 rst = 0 asserted in the 3rd REQ cycle -> next cycle dram_req_o = 0, FSM in IDLE, all outputs zero.
